// File: rtl/uart_rx_framer.sv
// UART receive framer: 8N1, LSB first, 16x oversampling.
// Raw rx is synchronized, framed by a four-state FSM and the completed byte
// is presented on a read-once register with valid/irq/overrun/frame_err flags.
module uart_rx_framer #(
  parameter int CLK_DIV = 651
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_irq,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic             rx_p0;
  logic             rx_s;
  logic             rx_prev;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [3:0]       sample_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             good_p1;
  logic             bad_p1;
  logic             start_edge;

  assign tick       = (tick_cnt == CNT_MAX);
  assign start_edge = (state == IDLE) && !rx_s && rx_prev;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_p0   <= rx;
      rx_s    <= rx_p0;
      rx_prev <= rx_s;
    end
  end

  // Oversample tick generator, realigned to the start edge of every frame
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (start_edge || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Framing FSM: start-bit qualification, data shift-in, stop-bit check
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      good_p1    <= 1'b0;
      bad_p1     <= 1'b0;
    end else begin
      good_p1 <= 1'b0;
      bad_p1  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state      <= START;
            sample_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (sample_cnt == 4'd7) begin
              // Mid start bit: still low means a real frame, else a glitch
              sample_cnt <= '0;
              bit_idx    <= '0;
              state      <= rx_s ? IDLE : DATA;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == 4'd15) begin
              shift[bit_idx] <= rx_s;
              bit_idx        <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == 4'd15) begin
              state   <= IDLE;
              good_p1 <= rx_s;
              bad_p1  <= !rx_s;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Host-facing data register and status flags; new events beat clears
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_irq    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_irq <= good_p1;
      if (good_p1) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (good_p1 && rx_valid && !rx_ack) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (bad_p1) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer with CLK_DIV = 4 (64 clk per bit).
// Good bytes are queued as frames are driven and popped on each rx_irq.
module tb_uart_rx_framer;

  localparam int CLK_DIV = 4;
  localparam int BIT_T   = 16 * CLK_DIV;
  localparam int FRAME_T = 10 * BIT_T;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ack;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_irq;
  logic       overrun;
  logic       frame_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   irq_cnt = 0;
  int   irq_cyc = 0;
  int   t_start = 0;
  int   irq_before;
  int   lat;
  logic [7:0] sb[$];
  logic [7:0] exp_b;

  uart_rx_framer #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_irq    (rx_irq),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return stop;
    return d[idx-1];
  endfunction

  // Drive one full frame cycle by cycle; optional pulses at given cycle offsets
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int ack_at, input int clr_at, input int rst_at);
    for (int k = 0; k < FRAME_T; k++) begin
      @(negedge clk);
      if (k == 0) t_start = cyc;
      rx      = frame_bit(d, stop, k / BIT_T);
      rx_ack  = (k == ack_at);
      err_clr = (k == clr_at);
      reset   = (rst_at >= 0) && (k >= rst_at) && (k < rst_at + 3);
    end
    @(negedge clk);
    rx      = 1'b1;
    rx_ack  = 1'b0;
    err_clr = 1'b0;
    reset   = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard consumer: every irq must match the oldest queued byte
  always @(negedge clk) begin
    if (rx_irq) begin
      irq_cnt++;
      irq_cyc = cyc;
      if (sb.size() == 0) begin
        chk("sb_unexpected_irq", 32'd1, 32'd0);
      end else begin
        exp_b = sb.pop_front();
        chk("sb_rx_data", rx_data, exp_b);
        chk("sb_rx_valid", rx_valid, 1'b1);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    rx_ack  = 1'b0;
    err_clr = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // reset state
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_irq", rx_irq, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);

    // single good byte and its latency
    irq_before = irq_cnt;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    lat = irq_cyc - t_start;
    chk("a5_irq_count", irq_cnt - irq_before, 1);
    chk("a5_latency_611pm1", (lat >= 610) && (lat <= 612), 1'b1);
    chk("a5_rx_data", rx_data, 8'hA5);
    chk("a5_rx_valid", rx_valid, 1'b1);
    chk("a5_overrun", overrun, 1'b0);
    chk("a5_frame_err", frame_err, 1'b0);
    pulse_ack();
    chk("a5_ack_clears_valid", rx_valid, 1'b0);
    pulse_ack();
    chk("ack_when_empty_valid", rx_valid, 1'b0);
    chk("ack_when_empty_overrun", overrun, 1'b0);

    // two bytes without a read: overrun, newest data kept
    irq_before = irq_cnt;
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1, -1);
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, -1, -1, -1);
    chk("ovr_irq_count", irq_cnt - irq_before, 2);
    chk("ovr_rx_data", rx_data, 8'hC3);
    chk("ovr_rx_valid", rx_valid, 1'b1);
    chk("ovr_overrun", overrun, 1'b1);
    pulse_clr();
    chk("ovr_err_clr", overrun, 1'b0);
    pulse_ack();

    // bad stop bit: frame error, no data update
    irq_before = irq_cnt;
    send_frame(8'h55, 1'b0, -1, -1, -1);
    chk("ferr_frame_err", frame_err, 1'b1);
    chk("ferr_rx_valid", rx_valid, 1'b0);
    chk("ferr_irq_count", irq_cnt - irq_before, 0);
    chk("ferr_rx_data_kept", rx_data, 8'hC3);
    // err_clr in the same cycle as a fresh frame error: error wins
    send_frame(8'h55, 1'b0, -1, FRAME_T - 29, -1);
    chk("ferr_set_beats_clr", frame_err, 1'b1);
    pulse_clr();
    chk("ferr_err_clr", frame_err, 1'b0);

    // short low glitch is rejected
    irq_before = irq_cnt;
    @(negedge clk); rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_rx_valid", rx_valid, 1'b0);
    chk("glitch_frame_err", frame_err, 1'b0);
    chk("glitch_overrun", overrun, 1'b0);
    chk("glitch_irq_count", irq_cnt - irq_before, 0);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1, -1, -1);
    chk("glitch_next_rx_data", rx_data, 8'h81);
    chk("glitch_next_rx_valid", rx_valid, 1'b1);
    pulse_ack();

    // read ack lands exactly on the completion of the second byte
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1, -1);
    sb.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, FRAME_T - 29, -1, -1);
    chk("ackcol_rx_data", rx_data, 8'h7E);
    chk("ackcol_rx_valid", rx_valid, 1'b1);
    chk("ackcol_overrun", overrun, 1'b0);

    // reset during data bit 3 abandons the frame and clears everything
    irq_before = irq_cnt;
    send_frame(8'hFF, 1'b1, -1, -1, 4 * BIT_T + 24);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_rx_irq", rx_irq, 1'b0);
    chk("midrst_overrun", overrun, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    chk("midrst_irq_count", irq_cnt - irq_before, 0);
    sb.push_back(8'h12);
    send_frame(8'h12, 1'b1, -1, -1, -1);
    chk("midrst_next_rx_data", rx_data, 8'h12);
    chk("midrst_next_rx_valid", rx_valid, 1'b1);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Parameters
REQ-001 SHALL provide parameter CLK_DIV, default 651, as the number of clk cycles per 16x-oversample tick (100 MHz / 9600 baud / 16).
REQ-002 SHALL accept any CLK_DIV >= 2; the counter width SHALL hold CLK_DIV-1.

Interface
REQ-003 clk  input  1  single clock for all state; one clock, everything on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rx_ack  input  1  one-cycle pulse from the peripheral bus read of the RX data register; clears rx_valid.
REQ-007 err_clr  input  1  one-cycle pulse; clears overrun and frame_err.
REQ-008 rx_data  output  8  last good received byte.
REQ-009 rx_valid  output  1  high while rx_data holds an unread byte.
REQ-010 rx_irq  output  1  one-cycle pulse per good byte, for the interrupt logic.
REQ-011 overrun  output  1  sticky; a byte was completed while rx_valid was still set.
REQ-012 frame_err  output  1  sticky; the stop bit was sampled low.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value (rx_s).
- Both synchronizer flops reset to 1.
REQ-014 Tick counter:
- counts 0..CLK_DIV-1 and asserts tick when it equals CLK_DIV-1, then wraps to 0;
- SHALL be forced to 0 in the cycle a start edge is detected.
REQ-015 A 4-bit sample counter SHALL count ticks within a bit; a 3-bit bit index SHALL count data bits.
REQ-016 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-017 IDLE: when rx_s is 0 and the previous rx_s is 1 (falling edge), go to START and clear the sample counter.
REQ-018 START: on the 8th tick (mid-bit), go to DATA if rx_s = 0; otherwise go to IDLE (glitch rejected, no flags).
REQ-019 DATA: every 16th tick, sample rx_s into shift bit [index], LSB first; go to STOP after bit index 7.
REQ-020 STOP: on the 16th tick, sample rx_s.
- If 1: the byte is good.
- If 0: set frame_err, discard the byte, leave rx_valid and rx_irq unchanged.
- In both cases go to IDLE.
REQ-021 On a good byte, in the cycle after the stop sample:
- rx_data <= shift register;
- rx_valid <= 1;
- rx_irq = 1 for exactly one cycle.
REQ-022 Overrun: if a good byte completes while rx_valid = 1 and rx_ack = 0, set overrun and still overwrite rx_data with the new byte.
REQ-023 Good-byte completion and rx_ack in the same cycle: new data loaded, rx_valid stays 1, overrun not set.
REQ-024 rx_ack with rx_valid = 0 SHALL have no effect.
REQ-025 If err_clr and a new error occur in the same cycle, the new error SHALL win (flag ends set).
REQ-026 Latency: rx_valid SHALL rise (8 + 16*9)*CLK_DIV + 3 clk cycles (+/-1) after the rx falling edge.

Reset
REQ-027 While reset = 1 on a rising edge:
- state = IDLE; all counters = 0; shift register = 0;
- rx_data = 0; rx_valid = 0; rx_irq = 0; overrun = 0; frame_err = 0; synchronizer = 1.
REQ-028 Reset mid-frame SHALL abandon the frame with no flag or data update.
- After reset releases, the next falling edge on rx starts a new frame.

Verification (CLK_DIV = 4, bit period = 64 clk)
REQ-029 Frame 0xA5 with stop = 1 -> rx_data = 0xA5, rx_valid = 1, one rx_irq pulse at 611 +/-1 cycles after the edge, overrun = 0, frame_err = 0.
REQ-030 0x3C followed by 0xC3 with no rx_ack -> rx_data = 0xC3, rx_valid = 1, overrun = 1, two rx_irq pulses; then err_clr -> overrun = 0.
REQ-031 0x55 with stop bit driven 0 -> frame_err = 1, rx_valid = 0, rx_irq never pulses, rx_data keeps its previous value.
REQ-032 20-cycle low glitch on an idle line -> FSM returns to IDLE; no flags, no rx_valid; a following 0x81 frame is received correctly.
REQ-033 rx_ack pulsed in the exact cycle the second byte 0x7E completes -> rx_data = 0x7E, rx_valid = 1, overrun = 0.
REQ-034 reset asserted during data bit 3 of 0xFF -> all outputs 0 after reset; a subsequent 0x12 frame is received as 0x12.
